// File: rtl/vec_pkg.sv
// Shared types and default sizes for the vector load/store unit.
// Build option: VEC_LSU_STRIDE_EN (see vec_addr_gen / vec_lsu).
package vec_pkg;

    localparam int ELEM_W_DEF   = 16;
    localparam int NUM_ELEM_DEF = 16;
    localparam int ADDR_W_DEF   = 16;

    // Transfer sequencer states; exported on the top-level state_dbg port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vec_lsu_if.sv
// Single-port memory bus between the vector LSU (master) and memory (slave).
// Handshake: there is no back-pressure. RD or WR high for one cycle is one
// access at Addr; RD and WR are never high together. Read data is returned
// on DataIn exactly one cycle after the RD cycle. dataOut is zero unless WR.
interface vec_lsu_if #(
    parameter int ADDR_W = 16,
    parameter int ELEM_W = 16
);
    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic              WR;
    logic [ELEM_W-1:0] dataOut;
    logic [ELEM_W-1:0] DataIn;

    modport master (
        output Addr,
        output RD,
        output WR,
        output dataOut,
        input  DataIn
    );

    modport slave (
        input  Addr,
        input  RD,
        input  WR,
        input  dataOut,
        output DataIn
    );
endinterface

// File: rtl/vec_addr_gen.sv
// Element address generator: loads the base address, then advances by the
// captured stride once per step; arithmetic wraps modulo 2^ADDR_W.
// Build option: VEC_LSU_STRIDE_EN. Without it the step is a fixed +1 and no
// stride register or stride port exists.
module vec_addr_gen #(
    parameter int ADDR_W = vec_pkg::ADDR_W_DEF
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
`ifdef VEC_LSU_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic [ADDR_W-1:0] addr
);

`ifdef VEC_LSU_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Address accumulator with stride captured at load; negative strides wrap naturally.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            addr     <= addr + stride_q;
        end
    end
`else
    // Unit-stride address counter.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= addr + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store unit: moves count+1 elements between a packed vector
// register and a single-port memory with read latency 1, one element per cycle.
// Build option: VEC_LSU_STRIDE_EN enables the signed stride input; otherwise
// the stride input is ignored and consecutive addresses are used.
module vec_lsu
    import vec_pkg::*;
#(
    parameter int ELEM_W   = ELEM_W_DEF,
    parameter int NUM_ELEM = NUM_ELEM_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                         Clk1,
    input  logic                         Reset,
    input  logic                         start,
    input  logic                         is_store,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [ADDR_W-1:0]            stride,
    input  logic [$clog2(NUM_ELEM)-1:0]  count,
    input  logic [NUM_ELEM*ELEM_W-1:0]   st_data,
    output logic [NUM_ELEM*ELEM_W-1:0]   ld_data,
    output logic                         busy,
    output logic                         done,
    output state_t                       state_dbg,
    vec_lsu_if.master                    mem
);

    localparam int CNT_W = $clog2(NUM_ELEM);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           idx_q;
    logic [CNT_W-1:0]           count_q;
    logic [NUM_ELEM*ELEM_W-1:0] st_q;
    logic                       rd_pend_q;
    logic [CNT_W-1:0]           rd_idx_q;
    logic [ADDR_W-1:0]          gen_addr;
    logic                       rd;
    logic                       wr;
    logic                       accept;
    logic                       last;

    assign accept    = (state_q == IDLE) && start;
    assign last      = (idx_q == count_q);
    assign state_dbg = state_q;

    vec_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .Clk1   (Clk1),
        .Reset  (Reset),
        .load   (accept),
        .step   ((rd || wr) && !last),
        .base   (base_addr),
`ifdef VEC_LSU_STRIDE_EN
        .stride (stride),
`endif
        .addr   (gen_addr)
    );

`ifndef VEC_LSU_STRIDE_EN
    logic unused_stride;
    assign unused_stride = ^stride;
`endif

    // State register; Reset wins over any pending start.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = is_store ? STORE : LOAD;
                end
            end
            LOAD: begin
                rd = 1'b1;
                if (last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            STORE: begin
                wr = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port drive; address and write data are forced to zero between accesses.
    always_comb begin
        mem.RD      = rd;
        mem.WR      = wr;
        mem.Addr    = (rd || wr) ? gen_addr : '0;
        mem.dataOut = wr ? st_q[int'(idx_q)*ELEM_W +: ELEM_W] : '0;
    end

    // Element index, captured request and load-return capture one cycle after each RD.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            idx_q     <= '0;
            count_q   <= '0;
            st_q      <= '0;
            ld_data   <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            rd_pend_q <= rd;
            rd_idx_q  <= idx_q;
            if (accept) begin
                idx_q   <= '0;
                count_q <= count;
                st_q    <= st_data;
                if (!is_store) begin
                    ld_data <= '0;
                end
            end else if ((rd || wr) && !last) begin
                idx_q <= idx_q + 1'b1;
            end
            if (rd_pend_q) begin
                ld_data[int'(rd_idx_q)*ELEM_W +: ELEM_W] <= mem.DataIn;
            end
        end
    end

endmodule

// File: tb/tb_vec_lsu.sv
// Directed self-checking bench for vec_lsu with a latency-1 memory model and
// an expected-operation queue for every memory access.
// Build option: VEC_LSU_STRIDE_EN selects strided or unit-stride expectations.
module tb_vec_lsu;
    import vec_pkg::*;

    localparam int ELEM_W   = 16;
    localparam int NUM_ELEM = 16;
    localparam int ADDR_W   = 16;
    localparam int OP_W     = 1 + ADDR_W + ELEM_W;
`ifdef VEC_LSU_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic                       Clk1 = 1'b0;
    logic                       Reset = 1'b1;
    logic                       start = 1'b0;
    logic                       is_store = 1'b0;
    logic [ADDR_W-1:0]          base_addr = '0;
    logic [ADDR_W-1:0]          stride = '0;
    logic [3:0]                 count = '0;
    logic [NUM_ELEM*ELEM_W-1:0] st_data = '0;
    logic [NUM_ELEM*ELEM_W-1:0] ld_data;
    logic                       busy;
    logic                       done;
    state_t                     state_dbg;

    always #5 Clk1 = ~Clk1;

    vec_lsu_if #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) mem_if ();

    vec_lsu #(
        .ELEM_W   (ELEM_W),
        .NUM_ELEM (NUM_ELEM),
        .ADDR_W   (ADDR_W)
    ) dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .stride    (stride),
        .count     (count),
        .st_data   (st_data),
        .ld_data   (ld_data),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .mem       (mem_if)
    );

    // Memory model: read data appears one cycle after the RD cycle.
    logic [ELEM_W-1:0] mem [0:65535];
    always @(posedge Clk1) begin
        if (mem_if.RD) mem_if.DataIn <= mem[mem_if.Addr];
        if (mem_if.WR) mem[mem_if.Addr] <= mem_if.dataOut;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [OP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] op(input bit wr, input logic [ADDR_W-1:0] a, input logic [ELEM_W-1:0] d);
        return {wr, a, d};
    endfunction

    function automatic logic [ADDR_W-1:0] el_addr(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, input int i);
        logic [ADDR_W-1:0] es;
        es = STRIDE_EN ? s : 16'd1;
        return b + 16'(i) * es;
    endfunction

    function automatic logic [ELEM_W-1:0] ld_el(input int i);
        return ld_data[i*ELEM_W +: ELEM_W];
    endfunction

    // Bus monitor: every access must match the next expected operation.
    always @(negedge Clk1) begin
        if (!Reset) begin
            if (!mem_if.WR) check("dout_idle", mem_if.dataOut, 0);
            if (mem_if.RD || mem_if.WR) begin
                check("rd_wr_excl", mem_if.RD & mem_if.WR, 0);
                check("op_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("mem_op", {mem_if.WR, mem_if.Addr, mem_if.dataOut}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_loads(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, input int c);
        for (int i = 0; i <= c; i++) exp_q.push_back(op(1'b0, el_addr(b, s, i), '0));
    endtask

    task automatic issue(input bit st, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                         input logic [3:0] c, input logic [NUM_ELEM*ELEM_W-1:0] sv);
        @(negedge Clk1);
        is_store  = st;
        base_addr = b;
        stride    = s;
        count     = c;
        st_data   = sv;
        start     = 1'b1;
        @(posedge Clk1);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; optionally keeps a
    // conflicting request on start through the DONE state.
    task automatic wait_done(input bit hold, output int lat);
        lat = 0;
        if (hold) begin
            start     = 1'b1;
            is_store  = ~is_store;
            base_addr = 16'h0300;
        end
        do begin
            @(negedge Clk1);
            lat++;
        end while (!done && lat < 64);
        check("done_seen", done, 1);
        @(posedge Clk1);
        #1 start = 1'b0;
        @(negedge Clk1);
        check("idle_after", busy, 0);
        check("state_after", state_dbg, IDLE);
        check("ops_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [NUM_ELEM*ELEM_W-1:0] sv;
        logic [ADDR_W-1:0] neg_a [3];

        // Reset state
        Reset = 1'b1;
        repeat (2) @(posedge Clk1);
        @(negedge Clk1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_if.RD, 0);
        check("rst_wr", mem_if.WR, 0);
        check("rst_addr", mem_if.Addr, 0);
        check("rst_dout", mem_if.dataOut, 0);
        check("rst_state", state_dbg, IDLE);
        for (int i = 0; i < NUM_ELEM; i++) check($sformatf("rst_ld%0d", i), ld_el(i), 0);
        Reset = 1'b0;

        // Unit-stride full load
        for (int i = 0; i < 16; i++) mem[16'h0010 + i] = 16'h1000 + 16'(i);
        expect_loads(16'h0010, 16'h0001, 15);
        issue(1'b0, 16'h0010, 16'h0001, 4'd15, '0);
        wait_done(1'b0, lat);
        check("ld16_lat", lat, 18);
        for (int i = 0; i < 16; i++) check($sformatf("ld16_el%0d", i), ld_el(i), 16'h1000 + i);

        // Strided store (unit addresses when stride is disabled)
        sv = '0;
        for (int i = 0; i < 4; i++) sv[i*ELEM_W +: ELEM_W] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 4; i++) exp_q.push_back(op(1'b1, el_addr(16'h0100, 16'h0004, i), 16'h00A0 + 16'(i)));
        issue(1'b1, 16'h0100, 16'h0004, 4'd3, sv);
        wait_done(1'b0, lat);
        check("st_lat", lat, 5);
        check("st_ld_hold", ld_el(15), 16'h100F);

        // Negative stride crossing address zero
        for (int i = 0; i < 3; i++) begin
            neg_a[i] = el_addr(16'h0001, 16'hFFFF, i);
            mem[neg_a[i]] = 16'h5A00 + 16'(i);
        end
        if (STRIDE_EN) check("neg_a2_wrap", neg_a[2], 16'hFFFF);
        expect_loads(16'h0001, 16'hFFFF, 2);
        issue(1'b0, 16'h0001, 16'hFFFF, 4'd2, '0);
        wait_done(1'b0, lat);
        check("neg_lat", lat, 5);
        for (int i = 0; i < 3; i++) check($sformatf("neg_el%0d", i), ld_el(i), 16'h5A00 + i);
        for (int i = 3; i < 16; i++) check($sformatf("neg_zero%0d", i), ld_el(i), 0);

        // Partial load over a previously full vector
        expect_loads(16'h0010, 16'h0001, 1);
        issue(1'b0, 16'h0010, 16'h0001, 4'd1, '0);
        wait_done(1'b0, lat);
        check("part_lat", lat, 4);
        check("part_el0", ld_el(0), 16'h1000);
        check("part_el1", ld_el(1), 16'h1001);
        for (int i = 2; i < 16; i++) check($sformatf("part_zero%0d", i), ld_el(i), 0);
        repeat (3) @(negedge Clk1);
        check("part_hold", ld_el(1), 16'h1001);

        // start held high while busy and through DONE
        for (int i = 0; i < 4; i++) mem[16'h0020 + i] = 16'h2200 + 16'(i);
        expect_loads(16'h0020, 16'h0001, 3);
        issue(1'b0, 16'h0020, 16'h0001, 4'd3, '0);
        wait_done(1'b1, lat);
        check("busy_lat", lat, 6);
        for (int i = 0; i < 4; i++) check($sformatf("busy_el%0d", i), ld_el(i), 16'h2200 + i);
        repeat (4) @(negedge Clk1);
        check("busy_no_retrigger", busy, 0);

        // Reset during the third LOAD cycle
        expect_loads(16'h0010, 16'h0001, 2);
        issue(1'b0, 16'h0010, 16'h0001, 4'd7, '0);
        repeat (3) @(negedge Clk1);
        #1 Reset = 1'b1;
        @(posedge Clk1);
        #1 Reset = 1'b0;
        @(negedge Clk1);
        check("abort_busy", busy, 0);
        check("abort_rd", mem_if.RD, 0);
        check("abort_state", state_dbg, IDLE);
        for (int i = 0; i < NUM_ELEM; i++) check($sformatf("abort_ld%0d", i), ld_el(i), 0);
        for (int k = 0; k < 8; k++) begin
            check("abort_no_done", done, 0);
            @(negedge Clk1);
        end
        check("abort_ops_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
